// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared constants for the 1x4 demux sequencer slice.
//   N_CH     : demux channel count (one word bit per channel)
//   SEL_W    : demux select width
//   ST_IDLE / ST_RUN : sequencer FSM encodings (legacy-compatible constants)
// -----------------------------------------------------------------------------
package demux_pkg;

   localparam int unsigned N_CH  = 4;
   localparam int unsigned SEL_W = 2;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/demux_1_4_seq_hold_counter.sv
// -----------------------------------------------------------------------------
// hold_counter
//   Counts 0..HOLD_CYCLES-1 while enabled and flags the final count.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear to 0 (has priority over en)
//   en   : advance the count this cycle
//   cnt  : current count
//   wrap : en & (cnt == HOLD_CYCLES-1)
// -----------------------------------------------------------------------------
module hold_counter #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned CNT_W       = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign wrap = en & (cnt_q == CNT_LAST);
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/demux_1_4_seq.sv
// -----------------------------------------------------------------------------
// demux_1_4_seq
//   Accepts a 4-bit word per valid/ready handshake and serialises it onto the
//   demux_1_4 inputs: bit k is driven on i0 while {s1,s0}=k, HOLD_CYCLES clocks
//   per slot. Back-to-back words run without a gap.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : in_data valid this cycle
//   in_data    : word to serialise, bit k goes out in slot k
//   in_ready   : word accepted this cycle when in_valid is high (combinational)
//   s0 / s1    : demux select LSB / MSB (registered)
//   i0         : demux data bit (registered)
//   slot_valid : s0/s1/i0 carry a live slot (registered)
//   frame_done : one-cycle pulse in the last cycle of slot 3 (registered)
// -----------------------------------------------------------------------------
module demux_1_4_seq
   import demux_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [N_CH-1:0] in_data,
   output logic            in_ready,
   output logic            s0,
   output logic            s1,
   output logic            i0,
   output logic            slot_valid,
   output logic            frame_done
);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [SEL_W-1:0] SLOT_LAST = SEL_W'(N_CH - 1);

   logic [0:0]       state_q, state_d;
   logic [N_CH-1:0]  word_q, word_d;
   logic [SEL_W-1:0] slot_q, slot_d;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             cnt_clr, cnt_en, wrap;
   logic             last, xfer, run_d;

   logic             s0_q, s1_q, i0_q, slot_valid_q, frame_done_q;
   logic             s0_d, s1_d, i0_d, slot_valid_d, frame_done_d;

   assign cnt_clr = (state_q == ST_IDLE);
   assign cnt_en  = (state_q == ST_RUN);

   hold_counter #(
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
   ) u_hold_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (cnt_clr),
      .en   (cnt_en),
      .cnt  (cnt),
      .wrap (wrap)
   );

   assign last     = (state_q == ST_RUN) && (slot_q == SLOT_LAST) && wrap;
   assign in_ready = ~rst & ((state_q == ST_IDLE) | last);
   assign xfer     = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      slot_d  = slot_q;
      case (state_q)
         ST_IDLE: begin
            if (xfer) begin
               state_d = ST_RUN;
               word_d  = in_data;
               slot_d  = '0;
            end
         end
         ST_RUN: begin
            if (wrap) begin
               if (slot_q == SLOT_LAST) begin
                  slot_d = '0;
                  if (xfer) begin
                     word_d = in_data;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  slot_d = slot_q + SEL_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with
   // the state/slot/count of the cycle they describe. cnt_nxt mirrors the
   // counter's own update (it cannot overflow: no wrap means cnt < last).
   always_comb begin
      run_d        = (state_d == ST_RUN);
      cnt_nxt      = ((state_q == ST_RUN) && !wrap) ? cnt + CNT_W'(1) : '0;
      slot_valid_d = run_d;
      s0_d         = run_d & slot_d[0];
      s1_d         = run_d & slot_d[1];
      i0_d         = run_d & word_d[slot_d];
      frame_done_d = run_d && (slot_d == SLOT_LAST) && (cnt_nxt == CNT_LAST);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         word_q       <= '0;
         slot_q       <= '0;
         s0_q         <= 1'b0;
         s1_q         <= 1'b0;
         i0_q         <= 1'b0;
         slot_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_q       <= word_d;
         slot_q       <= slot_d;
         s0_q         <= s0_d;
         s1_q         <= s1_d;
         i0_q         <= i0_d;
         slot_valid_q <= slot_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign s0         = s0_q;
   assign s1         = s1_q;
   assign i0         = i0_q;
   assign slot_valid = slot_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_demux_1_4_seq.sv
// -----------------------------------------------------------------------------
// tb_demux_1_4_seq
//   Directed bench for demux_1_4_seq with HOLD_CYCLES=4 and HOLD_CYCLES=1
//   instances. The downstream 1x4 demux is modelled inline from s0/s1/i0.
// -----------------------------------------------------------------------------
module tb_demux_1_4_seq;

   logic       clk = 1'b0;
   logic       rst;

   logic       v4, v1;
   logic [3:0] d4, d1;
   logic       rdy4, s0_4, s1_4, i0_4, sv4, fd4;
   logic       rdy1, s0_1, s1_1, i0_1, sv1, fd1;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   always #5 clk = ~clk;

   demux_1_4_seq #(.HOLD_CYCLES(4)) dut4 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (v4),
      .in_data    (d4),
      .in_ready   (rdy4),
      .s0         (s0_4),
      .s1         (s1_4),
      .i0         (i0_4),
      .slot_valid (sv4),
      .frame_done (fd4)
   );

   demux_1_4_seq #(.HOLD_CYCLES(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (v1),
      .in_data    (d1),
      .in_ready   (rdy1),
      .s0         (s0_1),
      .s1         (s1_1),
      .i0         (i0_1),
      .slot_valid (sv1),
      .frame_done (fd1)
   );

   // Packed view: {in_ready, slot_valid, frame_done, s1, s0, i0, out3..out0}
   function automatic logic [9:0] demux_vec(input logic rdy, input logic sv,
                                            input logic fd, input logic [1:0] sel,
                                            input logic b);
      logic [3:0] outs;
      outs = b ? (4'b0001 << sel) : 4'b0000;
      return {rdy, sv, fd, sel, b, outs};
   endfunction

   function automatic logic [9:0] obs4();
      return demux_vec(rdy4, sv4, fd4, {s1_4, s0_4}, i0_4);
   endfunction

   function automatic logic [9:0] obs1();
      return demux_vec(rdy1, sv1, fd1, {s1_1, s0_1}, i0_1);
   endfunction

   function automatic logic [9:0] expv(input logic rdy, input logic sv,
                                       input logic fd, input logic [1:0] sel,
                                       input logic b);
      return demux_vec(rdy, sv, fd, sv ? sel : 2'd0, sv & b);
   endfunction

   task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %b expected %b (rdy,sv,fd,s1,s0,i0,out3..0)", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated frame on the HOLD_CYCLES=4 instance.
   task automatic run_single(input string tag, input logic [3:0] word);
      logic [1:0] sel;
      check({tag, "_idle0"}, obs4(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
      v4 = 1'b1;
      d4 = word;
      tick();
      v4 = 1'b0;
      d4 = ~word;
      for (int c = 0; c < 16; c++) begin
         sel = 2'(c / 4);
         check($sformatf("%s_c%0d", tag, c), obs4(),
               expv(c == 15, 1'b1, c == 15, sel, word[sel]));
         tick();
      end
      check({tag, "_idle1"}, obs4(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
   endtask

   initial begin
      logic [1:0] sel;
      logic [3:0] w;

      rst = 1'b1;
      v4  = 1'b0;
      v1  = 1'b0;
      d4  = 4'h0;
      d1  = 4'h0;
      #1;
      check("reset_in", obs4(), 10'd0);
      check("reset_in_h1", obs1(), 10'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("post_reset", obs4(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));

      run_single("w1010", 4'b1010);
      tick();
      run_single("w0000", 4'b0000);

      // Back-to-back: 1111 then 0001, second accepted on the last cycle of slot 3.
      v4 = 1'b1;
      d4 = 4'b1111;
      tick();
      d4 = 4'b0001;
      for (int c = 0; c < 32; c++) begin
         w   = (c < 16) ? 4'b1111 : 4'b0001;
         sel = 2'((c % 16) / 4);
         if (c == 16) v4 = 1'b0;
         check($sformatf("b2b_c%0d", c), obs4(),
               expv((c % 16) == 15, 1'b1, (c % 16) == 15, sel, w[sel]));
         tick();
      end
      check("b2b_idle", obs4(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));

      // Backpressure: in_valid stays high with in_data churning mid-frame.
      v4 = 1'b1;
      d4 = 4'b0101;
      tick();
      for (int c = 0; c < 16; c++) begin
         sel = 2'(c / 4);
         w   = 4'b0101;
         d4  = 4'(c) ^ 4'b1010;
         if (c == 15) v4 = 1'b0;
         check($sformatf("bp_c%0d", c), obs4(),
               expv(c == 15, 1'b1, c == 15, sel, w[sel]));
         tick();
      end
      check("bp_idle", obs4(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));

      // HOLD_CYCLES=1 with 0110.
      check("h1_idle0", obs1(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
      v1 = 1'b1;
      d1 = 4'b0110;
      tick();
      v1 = 1'b0;
      d1 = 4'b1001;
      for (int c = 0; c < 4; c++) begin
         w   = 4'b0110;
         sel = 2'(c);
         check($sformatf("h1_c%0d", c), obs1(),
               expv(c == 3, 1'b1, c == 3, sel, w[sel]));
         tick();
      end
      check("h1_idle1", obs1(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));

      // Asynchronous reset mid-frame, then clean restart from IDLE.
      v4 = 1'b1;
      d4 = 4'b1111;
      tick();
      v4 = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      check("pre_rst", obs4(), expv(1'b0, 1'b1, 1'b0, 2'd1, 1'b1));
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid", obs4(), 10'd0);
      tick();
      rst = 1'b0;
      tick();
      check("rst_rel0", obs4(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
      tick();
      check("rst_rel1", obs4(), expv(1'b1, 1'b0, 1'b0, 2'd0, 1'b0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
